// File: rtl/mips_loader_pkg.sv
// Shared state encoding and constants for the instruction-memory loader.
package mips_loader_pkg;

   typedef enum logic [2:0] {
      LEN_HI = 3'd0,
      LEN_LO = 3'd1,
      DATA   = 3'd2,
      WRITE  = 3'd3,
      DONE   = 3'd4,
      ERR    = 3'd5
   } state_t;

   localparam int WORD_BYTES = 4;
   localparam int CNT_W      = 16;

endpackage

// File: rtl/word_assembler.sv
// Shifts incoming bytes into a big-endian 32-bit word; word_full marks the 4th byte.
module word_assembler
   import mips_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic [7:0]  byte_in,
   input  logic        byte_vld,
   output logic [31:0] word_out,
   output logic        word_full
);

   localparam int              BC_W = $clog2(WORD_BYTES);
   localparam logic [BC_W-1:0] LAST = BC_W'(WORD_BYTES - 1);

   logic [BC_W-1:0] byte_cnt;

   // Combinational so the owner can register the write on the same edge as the last byte.
   assign word_full = byte_vld && (byte_cnt == LAST);

   // NOTE: sequential state is updated with non-blocking assignments only, so every
   // register samples the values from before the edge regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_out <= '0;
         byte_cnt <= '0;
      end else if (clear) begin
         word_out <= '0;
         byte_cnt <= '0;
      end else if (byte_vld) begin
         word_out <= {word_out[23:0], byte_in};
         byte_cnt <= byte_cnt + BC_W'(1);
      end
   end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a length-prefixed byte stream into instruction memory and holds the CPU in reset until done.
module instr_mem_loader #(
   parameter int DEPTH = 64,
   parameter int CNT_W = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   input  logic        start,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_rst_n,
   output logic        done,
   output logic        error
);
   import mips_loader_pkg::*;

   localparam int               IDX_W   = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [IDX_W-1:0] word_idx;
   logic             hs;
   logic             rearm;
   logic             word_full;
   logic [31:0]      asm_word;
   logic [CNT_W-1:0] full_count;
   logic             last_word;

   assign rx_ready   = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
   assign hs         = rx_valid && rx_ready;
   assign rearm      = start && ((state == DONE) || (state == ERR));
   assign full_count = {count[CNT_W-1:8], rx_data};
   assign last_word  = (CNT_W'(word_idx) == (count - CNT_W'(1)));

   word_assembler u_asm (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (rearm),
      .byte_in   (rx_data),
      .byte_vld  (hs && (state == DATA)),
      .word_out  (asm_word),
      .word_full (word_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LEN_HI;
         count     <= '0;
         word_idx  <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         done      <= 1'b0;
         error     <= 1'b0;
         cpu_rst_n <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            LEN_HI: if (hs) begin
               count[CNT_W-1:8] <= rx_data;
               state            <= LEN_LO;
            end
            LEN_LO: if (hs) begin
               count <= full_count;
               if (full_count == '0) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  cpu_rst_n <= 1'b1;
               end else if (full_count > DEPTH_C) begin
                  state <= ERR;
                  error <= 1'b1;
               end else begin
                  state <= DATA;
               end
            end
            // The 4th byte is folded in here so the write pulse lands in the WRITE cycle.
            DATA: if (word_full) begin
               state     <= WRITE;
               mem_we    <= 1'b1;
               mem_addr  <= 32'(word_idx) << 2;
               mem_wdata <= {asm_word[23:0], rx_data};
            end
            WRITE: begin
               if (last_word) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  cpu_rst_n <= 1'b1;
               end else begin
                  word_idx <= word_idx + IDX_W'(1);
                  state    <= DATA;
               end
            end
            DONE, ERR: if (start) begin
               state     <= LEN_HI;
               done      <= 1'b0;
               error     <= 1'b0;
               cpu_rst_n <= 1'b0;
               word_idx  <= '0;
            end
            default: state <= LEN_HI;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: table of headers with random payloads plus corner sequences.
module tb_instr_mem_loader;

   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        start = 1'b0;
   logic        rx_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_rst_n;
   logic        done;
   logic        error;

   instr_mem_loader #(.DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .start     (start),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_rst_n (cpu_rst_n),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [7:0]  tx_q[$];
   logic [63:0] exp_q[$];
   logic [63:0] obs_q[$];
   bit          exp_done;
   bit          exp_err;
   int          n_send;
   int          we_with_ready = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Every write pulse is recorded; a write while rx_ready is high would mean a stall-cycle write.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         obs_q.push_back({mem_addr, mem_wdata});
         if (rx_ready !== 1'b0) we_with_ready++;
      end
   end

   // Reference model: header gives the word count; each 4 payload bytes form one big-endian word.
   function automatic void build_expect();
      int cnt;
      exp_q.delete();
      cnt      = int'(tx_q[0]) * 256 + int'(tx_q[1]);
      exp_err  = (cnt > DEPTH);
      exp_done = !exp_err;
      n_send   = exp_err ? 2 : 2 + 4 * cnt;
      if (!exp_err)
         for (int w = 0; w < cnt; w++)
            exp_q.push_back({32'(w * 4), tx_q[2+4*w], tx_q[3+4*w], tx_q[4+4*w], tx_q[5+4*w]});
   endfunction

   function automatic void make_stream(input logic [15:0] cnt);
      tx_q.delete();
      tx_q.push_back(cnt[15:8]);
      tx_q.push_back(cnt[7:0]);
      if (cnt >= 16'd1 && cnt <= 16'(DEPTH))
         for (int i = 0; i < 4 * int'(cnt); i++) tx_q.push_back(8'($urandom));
   endfunction

   // Called at a falling edge; returns at the falling edge after the handshake with rx_valid low.
   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (rx_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (rx_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL send_byte: rx_ready stayed 0 for %0d cycles", waited);
      end else begin
         @(posedge clk);
         @(negedge clk);
      end
      rx_valid = 1'b0;
   endtask

   // mode 0: back-to-back, 1: one idle cycle after every byte, 2: random idle gaps.
   task automatic send_range(input int lo, input int hi, input int mode);
      for (int i = lo; i < hi; i++) begin
         send_byte(tx_q[i]);
         if (mode == 1) @(negedge clk);
         else if (mode == 2) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic finish_load(input string name);
      int waited = 0;
      int n;
      while (done !== 1'b1 && error !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check({name, "_cpu_rst_n"}, cpu_rst_n, exp_done);
      check({name, "_rx_ready"}, rx_ready, 0);
      check({name, "_nwrites"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_addr%0d", name, i), obs_q[i][63:32], exp_q[i][63:32]);
         check($sformatf("%s_data%0d", name, i), obs_q[i][31:0], exp_q[i][31:0]);
      end
   endtask

   task automatic rearm(input string name);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({name, "_rearm_ready"}, rx_ready, 1);
      check({name, "_rearm_done"}, done, 0);
      check({name, "_rearm_error"}, error, 0);
      check({name, "_rearm_cpu_rst_n"}, cpu_rst_n, 0);
   endtask

   typedef struct {
      logic [15:0] count;
      int          mode;
      bit          want_done;
      bit          want_err;
   } vec_t;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[8];
      vecs[0] = '{16'd1,    2, 1'b1, 1'b0};
      vecs[1] = '{16'd3,    2, 1'b1, 1'b0};
      vecs[2] = '{16'd0,    0, 1'b1, 1'b0};
      vecs[3] = '{16'd65,   0, 1'b0, 1'b1};
      vecs[4] = '{16'd64,   1, 1'b1, 1'b0};
      vecs[5] = '{16'hFFFF, 0, 1'b0, 1'b1};
      vecs[6] = '{16'h0100, 0, 1'b0, 1'b1};
      vecs[7] = '{16'd7,    2, 1'b1, 1'b0};

      repeat (3) @(negedge clk);
      check("reset_rx_ready", rx_ready, 1);
      check("reset_mem_we", mem_we, 0);
      check("reset_done", done, 0);
      check("reset_error", error, 0);
      check("reset_cpu_rst_n", cpu_rst_n, 0);
      check("reset_mem_addr", mem_addr, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Two-word program, no stalls.
      tx_q = '{8'h00, 8'h02, 8'h20, 8'h10, 8'h00, 8'h00, 8'h20, 8'h11, 8'h00, 8'h00};
      build_expect();
      obs_q.delete();
      send_range(0, n_send, 0);
      finish_load("two_word");
      check("two_word_done", done, 1);
      check("two_word_w1", (obs_q.size() > 1) ? obs_q[1][31:0] : 32'h0, 32'h20110000);
      repeat (3) @(negedge clk);
      check("two_word_ready_stays0", rx_ready, 0);
      rearm("two_word");

      // Zero-length header: done registered on the LEN_LO handshake edge.
      tx_q = '{8'h00, 8'h00};
      build_expect();
      obs_q.delete();
      send_byte(8'h00);
      send_byte(8'h00);
      check("zero_done_latency", done, 1);
      finish_load("zero");
      rearm("zero");

      foreach (vecs[k]) begin
         make_stream(vecs[k].count);
         build_expect();
         obs_q.delete();
         send_range(0, n_send, vecs[k].mode);
         finish_load($sformatf("vec%0d", k));
         check($sformatf("vec%0d_done", k), done, vecs[k].want_done);
         check($sformatf("vec%0d_error", k), error, vecs[k].want_err);
         rearm($sformatf("vec%0d", k));
      end

      // Asynchronous reset in the middle of the first word.
      make_stream(16'd2);
      obs_q.delete();
      send_range(0, 4, 0);
      #2 rst_n = 1'b0;
      #1;
      check("async_mem_we", mem_we, 0);
      check("async_mem_addr", mem_addr, 0);
      check("async_mem_wdata", mem_wdata, 0);
      check("async_done", done, 0);
      check("async_error", error, 0);
      check("async_cpu_rst_n", cpu_rst_n, 0);
      check("async_rx_ready", rx_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tx_q = '{8'h00, 8'h01, 8'hAC, 8'h14, 8'h00, 8'h0C};
      build_expect();
      obs_q.delete();
      send_range(0, n_send, 0);
      finish_load("reload");
      check("reload_data", (obs_q.size() > 0) ? obs_q[0][31:0] : 32'h0, 32'hAC14000C);
      check("reload_done", done, 1);
      rearm("reload");

      // start pulse during DATA must be ignored.
      make_stream(16'd2);
      build_expect();
      obs_q.delete();
      send_range(0, 4, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_in_data_ready", rx_ready, 1);
      send_range(4, n_send, 0);
      finish_load("start_in_data");
      check("start_in_data_done", done, 1);

      check("no_write_while_ready", we_with_ready, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Write-side companion to the instruction memory.
- Receives a length-prefixed byte stream over a valid/ready handshake, e.g. from a UART receiver, and assembles big-endian 32-bit instructions.
- Issues one write strobe per word into the instruction memory's write port.
- Holds the CPU in reset until the program is fully loaded.

Parameters:
- DEPTH, 64, instruction memory capacity in 32-bit words; largest accepted word count.
- CNT_W, 16, width of the word-count header in bits; always 16.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_ready  output  1  loader accepts a byte this cycle; transfer occurs when rx_valid and rx_ready are both 1.
- start  input  1  single-cycle pulse; re-arms the loader from DONE or ERR.
- mem_we  output  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr  output  32  byte address of the word being written; always a multiple of 4.
- mem_wdata  output  32  assembled instruction.
- cpu_rst_n  output  1  active-low reset to the CPU; 0 while loading or in error.
- done  output  1  program loaded.
- error  output  1  header word count exceeded DEPTH.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State LEN_HI; word_idx=0; byte_cnt=0; count=0.
  - mem_we=0, mem_addr=0, mem_wdata=0, done=0, error=0, cpu_rst_n=0.
  - rx_ready is a decode of state, so it reads 1 in LEN_HI.
  - Reset mid-load abandons the load. Words already written stay in memory. The loader restarts at LEN_HI.
- States:
  - LEN_HI: rx_ready=1. On handshake, count[15:8]=rx_data, go to LEN_LO.
  - LEN_LO: rx_ready=1. On handshake, count[7:0]=rx_data.
    - Full count = 0: go to DONE.
    - Full count > DEPTH: go to ERR.
    - Otherwise: go to DATA.
  - DATA: rx_ready=1. On each handshake, shift the byte into the assembly register; the first byte lands in bits [31:24].
    - byte_cnt 0..3, wraps to 0.
    - On the 4th byte, go to WRITE.
    - Cycles with rx_valid=0 stall with no state change.
  - WRITE: rx_ready=0. For exactly one cycle: mem_we=1, mem_addr=word_idx<<2, mem_wdata=assembled word.
    - If word_idx==count-1, go to DONE.
    - Otherwise word_idx+1 and go to DATA.
  - DONE: rx_ready=0, done=1, cpu_rst_n=1.
  - ERR: rx_ready=0, error=1, cpu_rst_n=0.
  - start=1 in DONE or ERR: go to LEN_HI, clear done, error, word_idx and byte_cnt; cpu_rst_n=0 from the next cycle.
  - start is ignored in all other states.
- Registering and timing:
  - mem_we, mem_addr, mem_wdata, done, error and cpu_rst_n are registered.
  - mem_addr and mem_wdata hold their last value when mem_we=0.
  - Latency: the 4th byte's handshake is at edge N; mem_we=1 in the cycle after edge N.
  - Minimum 5 cycles per word.
- Boundary conditions:
  - count==DEPTH is accepted; the last write is to address (DEPTH-1)*4.
  - count==DEPTH+1 goes to ERR.
  - No handshake can occur in WRITE, DONE or ERR, because rx_ready=0 there.
- Arithmetic:
  - word_idx is clog2(DEPTH+1) bits wide and never exceeds count-1.
  - The address is zero-extended to 32 bits.

Decomposition:
- Shared package mips_loader_pkg holds:
  - state enum LEN_HI=0, LEN_LO=1, DATA=2, WRITE=3, DONE=4, ERR=5 (3 bits);
  - constant WORD_BYTES=4;
  - constant CNT_W=16.
- One natural sub-module, word_assembler:
  - inputs: clk, rst_n, clear, byte_in, byte_vld;
  - outputs: word_out[31:0], word_full, which pulses with the 4th byte;
  - contains the shift register and byte_cnt.
- The top-level FSM, index counter and write port live in instr_mem_loader.

Test Plan:
- Bytes 00 02 20 10 00 00 20 11 00 00, no stalls:
  - mem_we pulses twice: (addr 0x0, data 0x20100000), then (addr 0x4, data 0x20110000);
  - then done=1 and cpu_rst_n=1, and rx_ready=0 thereafter.
- Header 00 00:
  - DONE one cycle after the LEN_LO handshake;
  - no mem_we pulse, done=1.
- Header 00 41 (65) with DEPTH=64:
  - error=1, cpu_rst_n=0, rx_ready=0, no mem_we.
  - start pulse gives LEN_HI, error=0, rx_ready=1.
- Header 00 40 and 256 data bytes, with rx_valid toggled 1/0 every cycle:
  - 64 writes;
  - last write addr 0xFC, data equal to the last 4 bytes sent;
  - no write during stall cycles.
- rst_n=0 asserted asynchronously after the 2nd data byte of word 1:
  - all outputs go to reset values immediately.
  - Reloading 00 01 AC 14 00 0C writes addr 0x0, data 0xAC14000C.
- start pulsed while in DATA:
  - ignored; the load completes normally and done rises as expected.
